// File: rtl/ace_snoop_collector_if.sv
`default_nettype none
// ============================================================================
// Module   : ace_snoop_collector_if
// Brief    : Request, AC, CR and merged-response bundle of the snoop collector.
// Revision : 1.0
// ============================================================================
interface ace_snoop_collector_if #(
  parameter int NumPorts  = 4,
  parameter int AddrWidth = 64,
  parameter int IdxWidth  = $clog2(NumPorts)
);

  typedef logic [3:0] acsnoop_t;

  typedef struct packed {
    acsnoop_t snoop_trs;
    logic     accepts_dirty;
    logic     accepts_dirty_shared;
    logic     accepts_shared;
    logic     excl_load;
    logic     excl_store;
  } snoop_info_t;

  // Request side
  logic                          req_valid_i;
  logic                          req_ready_o;
  logic [AddrWidth-1:0]          req_addr_i;
  snoop_info_t                   req_info_i;
  logic [IdxWidth-1:0]           req_src_i;

  // AC channel, one valid/ready pair per snooped master
  logic [NumPorts-1:0]           ac_valid_o;
  logic [NumPorts-1:0]           ac_ready_i;
  logic [AddrWidth-1:0]          ac_addr_o;
  acsnoop_t                      ac_snoop_o;

  // CR channel: [0] DataTransfer [1] Error [2] PassDirty [3] IsShared [4] WasUnique
  logic [NumPorts-1:0]           cr_valid_i;
  logic [NumPorts-1:0]           cr_ready_o;
  logic [NumPorts-1:0][4:0]      cr_resp_i;

  // Merged result
  logic                          rsp_valid_o;
  logic                          rsp_ready_i;
  logic                          rsp_data_o;
  logic [IdxWidth-1:0]           rsp_data_src_o;
  logic                          rsp_dirty_o;
  logic                          rsp_shared_o;
  logic                          rsp_writeback_o;
  logic                          rsp_error_o;
  logic                          rsp_excl_load_o;
  logic                          rsp_excl_store_o;

  modport slave (
    input  req_valid_i, req_addr_i, req_info_i, req_src_i,
    input  ac_ready_i, cr_valid_i, cr_resp_i, rsp_ready_i,
    output req_ready_o, ac_valid_o, ac_addr_o, ac_snoop_o, cr_ready_o,
    output rsp_valid_o, rsp_data_o, rsp_data_src_o, rsp_dirty_o, rsp_shared_o,
    output rsp_writeback_o, rsp_error_o, rsp_excl_load_o, rsp_excl_store_o
  );

  modport master (
    output req_valid_i, req_addr_i, req_info_i, req_src_i,
    output ac_ready_i, cr_valid_i, cr_resp_i, rsp_ready_i,
    input  req_ready_o, ac_valid_o, ac_addr_o, ac_snoop_o, cr_ready_o,
    input  rsp_valid_o, rsp_data_o, rsp_data_src_o, rsp_dirty_o, rsp_shared_o,
    input  rsp_writeback_o, rsp_error_o, rsp_excl_load_o, rsp_excl_store_o
  );

endinterface
`default_nettype wire

// File: rtl/ace_snoop_collector.sv
`default_nettype none
// ============================================================================
// Module   : ace_snoop_collector
// Brief    : Broadcasts one snoop on AC to all non-initiating masters and
//            merges their CR responses into a single read-path decision.
// Revision : 1.0
// ============================================================================
module ace_snoop_collector #(
  parameter int NumPorts  = 4,
  parameter int AddrWidth = 64,
  parameter int IdxWidth  = $clog2(NumPorts)
) (
  input  wire logic              clk_i,
  input  wire logic              rst_i,
  ace_snoop_collector_if.slave   bus
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_RESP = 2'd2
  } state_t;

  state_t                r_state;
  state_t                w_state_nxt;

  logic [AddrWidth-1:0]  r_addr;
  logic [3:0]            r_snoop;
  logic                  r_acc_dirty;
  logic                  r_acc_dirty_shared;
  logic                  r_acc_shared;
  logic                  r_excl_load;
  logic                  r_excl_store;

  logic [NumPorts-1:0]   r_ac_pend, w_ac_pend_nxt;
  logic [NumPorts-1:0]   r_cr_pend, w_cr_pend_nxt;
  logic [NumPorts-1:0]   w_ac_hs;
  logic [NumPorts-1:0]   w_cr_hs;
  logic [NumPorts-1:0]   w_src_mask;

  logic                  r_any_data,   w_any_data_nxt;
  logic                  r_any_dirty,  w_any_dirty_nxt;
  logic                  r_any_shared, w_any_shared_nxt;
  logic                  r_any_err,    w_any_err_nxt;
  logic [IdxWidth-1:0]   r_data_src,   w_data_src_nxt;

  logic                  w_hit;
  logic [IdxWidth-1:0]   w_hit_idx;
  logic                  w_accept;
  logic                  w_in_resp;
  logic                  w_dirty;

  always_comb begin
    w_state_nxt      = r_state;
    w_ac_pend_nxt    = r_ac_pend;
    w_cr_pend_nxt    = r_cr_pend;
    w_any_data_nxt   = r_any_data;
    w_any_dirty_nxt  = r_any_dirty;
    w_any_shared_nxt = r_any_shared;
    w_any_err_nxt    = r_any_err;
    w_data_src_nxt   = r_data_src;
    w_ac_hs          = '0;
    w_cr_hs          = '0;
    w_hit            = 1'b0;
    w_hit_idx        = '0;
    w_accept         = 1'b0;
    w_src_mask       = '1;
    w_src_mask[bus.req_src_i] = 1'b0;

    bus.req_ready_o  = 1'b0;
    bus.ac_valid_o   = '0;
    bus.cr_ready_o   = '0;
    bus.rsp_valid_o  = 1'b0;

    case (r_state)
      S_IDLE: begin
        bus.req_ready_o = 1'b1;
        if (bus.req_valid_i) begin
          w_accept         = 1'b1;
          w_ac_pend_nxt    = w_src_mask;
          w_cr_pend_nxt    = w_src_mask;
          w_any_data_nxt   = 1'b0;
          w_any_dirty_nxt  = 1'b0;
          w_any_shared_nxt = 1'b0;
          w_any_err_nxt    = 1'b0;
          w_data_src_nxt   = '0;
          w_state_nxt      = S_BUSY;
        end
      end

      S_BUSY: begin
        // CR is held off on a port until its AC has been taken.
        bus.ac_valid_o = r_ac_pend;
        bus.cr_ready_o = r_cr_pend & ~r_ac_pend;
        w_ac_hs        = r_ac_pend & bus.ac_ready_i;
        w_cr_hs        = r_cr_pend & ~r_ac_pend & bus.cr_valid_i;

        for (int i = 0; i < NumPorts; i++) begin
          if (w_cr_hs[i]) begin
            w_any_data_nxt   = w_any_data_nxt   | bus.cr_resp_i[i][0];
            w_any_dirty_nxt  = w_any_dirty_nxt  | bus.cr_resp_i[i][2];
            w_any_shared_nxt = w_any_shared_nxt | bus.cr_resp_i[i][3];
            w_any_err_nxt    = w_any_err_nxt    | bus.cr_resp_i[i][1]
                             | (bus.cr_resp_i[i][2] & ~bus.cr_resp_i[i][0]);
          end
        end

        // Descending scan leaves the lowest responding index in w_hit_idx.
        for (int i = NumPorts - 1; i >= 0; i--) begin
          if (w_cr_hs[i] && bus.cr_resp_i[i][0]) begin
            w_hit     = 1'b1;
            w_hit_idx = IdxWidth'(i);
          end
        end
        if (w_hit && (!r_any_data || (w_hit_idx < r_data_src))) begin
          w_data_src_nxt = w_hit_idx;
        end

        w_ac_pend_nxt = r_ac_pend & ~w_ac_hs;
        w_cr_pend_nxt = r_cr_pend & ~w_cr_hs;
        if ((w_ac_pend_nxt == '0) && (w_cr_pend_nxt == '0)) begin
          w_state_nxt = S_RESP;
        end
      end

      S_RESP: begin
        bus.rsp_valid_o = 1'b1;
        if (bus.rsp_ready_i) begin
          w_state_nxt = S_IDLE;
        end
      end

      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state            <= S_IDLE;
      r_addr             <= '0;
      r_snoop            <= '0;
      r_acc_dirty        <= 1'b0;
      r_acc_dirty_shared <= 1'b0;
      r_acc_shared       <= 1'b0;
      r_excl_load        <= 1'b0;
      r_excl_store       <= 1'b0;
      r_ac_pend          <= '0;
      r_cr_pend          <= '0;
      r_any_data         <= 1'b0;
      r_any_dirty        <= 1'b0;
      r_any_shared       <= 1'b0;
      r_any_err          <= 1'b0;
      r_data_src         <= '0;
    end else begin
      r_state      <= w_state_nxt;
      r_ac_pend    <= w_ac_pend_nxt;
      r_cr_pend    <= w_cr_pend_nxt;
      r_any_data   <= w_any_data_nxt;
      r_any_dirty  <= w_any_dirty_nxt;
      r_any_shared <= w_any_shared_nxt;
      r_any_err    <= w_any_err_nxt;
      r_data_src   <= w_data_src_nxt;
      if (w_accept) begin
        r_addr             <= bus.req_addr_i;
        r_snoop            <= bus.req_info_i.snoop_trs;
        r_acc_dirty        <= bus.req_info_i.accepts_dirty;
        r_acc_dirty_shared <= bus.req_info_i.accepts_dirty_shared;
        r_acc_shared       <= bus.req_info_i.accepts_shared;
        r_excl_load        <= bus.req_info_i.excl_load;
        r_excl_store       <= bus.req_info_i.excl_store;
      end
    end
  end

  // Dirty data goes to the initiator only if it can hold it in the resulting
  // state; otherwise the interconnect must write it back.
  assign w_in_resp = (r_state == S_RESP);
  assign w_dirty   = r_any_dirty && r_acc_dirty && (!r_any_shared || r_acc_dirty_shared);

  assign bus.ac_addr_o        = r_addr;
  assign bus.ac_snoop_o       = r_snoop;
  assign bus.rsp_data_o       = w_in_resp && r_any_data;
  assign bus.rsp_data_src_o   = (w_in_resp && r_any_data) ? r_data_src : '0;
  assign bus.rsp_dirty_o      = w_in_resp && w_dirty;
  assign bus.rsp_shared_o     = w_in_resp && r_any_shared;
  assign bus.rsp_writeback_o  = w_in_resp && r_any_dirty && !w_dirty;
  assign bus.rsp_error_o      = w_in_resp && (r_any_err || (r_any_shared && !r_acc_shared));
  assign bus.rsp_excl_load_o  = w_in_resp && r_excl_load;
  assign bus.rsp_excl_store_o = w_in_resp && r_excl_store;

endmodule
`default_nettype wire

// File: tb/tb_ace_snoop_collector.sv
`default_nettype none
// ============================================================================
// Module   : tb_ace_snoop_collector
// Brief    : Directed snoop vectors with hand-computed merged results.
// Revision : 1.0
// ============================================================================
module tb_ace_snoop_collector;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  ace_snoop_collector_if #(.NumPorts(4), .AddrWidth(64)) bus ();

  ace_snoop_collector #(.NumPorts(4), .AddrWidth(64)) dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus)
  );

  typedef struct {
    int             src;
    logic [3:0]     trs;
    logic [4:0]     acc;    // {accepts_dirty, accepts_dirty_shared, accepts_shared, excl_load, excl_store}
    logic [4:0]     resp [4];
    logic [15:0]    acd;    // per-port AC ready delay, nibble per port
    logic [15:0]    crd;    // per-port CR delay after AC handshake
    logic [3:0]     early;  // CR valid raised before AC handshake
    int             hold;
    int             lat;    // expected cycle of rsp_valid after accept, 0 = unchecked
    logic [4:0]     exp;    // {data, dirty, shared, writeback, error}
    logic [1:0]     esrc;
  } vec_t;

  int n_chk  = 0;
  int n_fail = 0;
  vec_t vt [11];

  function automatic vec_t mk(int src, logic [3:0] trs, logic [4:0] acc,
                              logic [4:0] r0, logic [4:0] r1, logic [4:0] r2, logic [4:0] r3,
                              logic [15:0] acd, logic [15:0] crd, logic [3:0] early,
                              int hold, int lat, logic [4:0] exp, logic [1:0] esrc);
    vec_t v;
    v.src = src; v.trs = trs; v.acc = acc;
    v.resp[0] = r0; v.resp[1] = r1; v.resp[2] = r2; v.resp[3] = r3;
    v.acd = acd; v.crd = crd; v.early = early;
    v.hold = hold; v.lat = lat; v.exp = exp; v.esrc = esrc;
    return v;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    n_chk++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h, required %0h", name, act, req);
    end
  endtask

  function automatic logic [6:0] outs();
    return {bus.rsp_data_o, bus.rsp_dirty_o, bus.rsp_shared_o, bus.rsp_writeback_o,
            bus.rsp_error_o, bus.rsp_data_src_o};
  endfunction

  task automatic idle_inputs();
    bus.req_valid_i = 1'b0;
    bus.req_addr_i  = '0;
    bus.req_info_i  = '0;
    bus.req_src_i   = '0;
    bus.ac_ready_i  = '0;
    bus.cr_valid_i  = '0;
    bus.cr_resp_i   = '0;
    bus.rsp_ready_i = 1'b0;
  endtask

  // Entered and left at a negative clock edge.
  task automatic run_vec(input vec_t v, input int id);
    logic [3:0]  ac_done, cr_done;
    int          ac_cyc [4];
    int          last_cr = 0;
    int          cyc;
    bit          src_seen = 0;
    bit          early_rdy = 0;
    logic [63:0] addr;

    addr = 64'hA5A5_0000_0000_0040 + 64'(id) * 64'h1000;
    chk($sformatf("v%0d req_ready_idle", id), 64'(bus.req_ready_o), 64'd1);
    bus.req_valid_i = 1'b1;
    bus.req_addr_i  = addr;
    bus.req_src_i   = 2'(v.src);
    bus.req_info_i  = {v.trs, v.acc};
    for (int p = 0; p < 4; p++) bus.cr_resp_i[p] = v.resp[p];
    ac_done = '0;
    cr_done = '0;
    ac_done[v.src] = 1'b1;
    cr_done[v.src] = 1'b1;
    for (int p = 0; p < 4; p++) ac_cyc[p] = 0;
    @(posedge clk);
    @(negedge clk);
    bus.req_valid_i = 1'b0;
    chk($sformatf("v%0d ac_addr", id), bus.ac_addr_o, addr);
    chk($sformatf("v%0d ac_snoop", id), 64'(bus.ac_snoop_o), 64'(v.trs));
    cyc = 1;
    while (!bus.rsp_valid_o && cyc < 200) begin
      for (int p = 0; p < 4; p++) begin
        bus.ac_ready_i[p] = !ac_done[p] && (cyc >= 1 + int'(v.acd[4*p +: 4]));
        bus.cr_valid_i[p] = !cr_done[p] &&
                            (v.early[p] || (ac_done[p] && cyc >= ac_cyc[p] + 1 + int'(v.crd[4*p +: 4])));
      end
      if (bus.ac_valid_o[v.src] || bus.cr_ready_o[v.src]) src_seen = 1;
      for (int p = 0; p < 4; p++) begin
        if (bus.cr_ready_o[p] && !ac_done[p]) early_rdy = 1;
        if (bus.ac_valid_o[p] && bus.ac_ready_i[p]) begin
          ac_done[p] = 1'b1;
          ac_cyc[p]  = cyc;
        end
        if (bus.cr_valid_i[p] && bus.cr_ready_o[p]) begin
          cr_done[p] = 1'b1;
          last_cr    = cyc;
        end
      end
      @(posedge clk);
      @(negedge clk);
      cyc++;
    end
    bus.ac_ready_i = '0;
    bus.cr_valid_i = '0;

    chk($sformatf("v%0d rsp_valid_seen", id), 64'(bus.rsp_valid_o), 64'd1);
    chk($sformatf("v%0d rsp_after_last_cr", id), 64'(cyc), 64'(last_cr + 1));
    if (v.lat != 0) chk($sformatf("v%0d latency", id), 64'(cyc), 64'(v.lat));
    chk($sformatf("v%0d src_port_touched", id), 64'(src_seen), 64'd0);
    chk($sformatf("v%0d cr_ready_before_ac", id), 64'(early_rdy), 64'd0);
    chk($sformatf("v%0d data", id), 64'(bus.rsp_data_o), 64'(v.exp[4]));
    chk($sformatf("v%0d data_src", id), 64'(bus.rsp_data_src_o), 64'(v.esrc));
    chk($sformatf("v%0d dirty", id), 64'(bus.rsp_dirty_o), 64'(v.exp[3]));
    chk($sformatf("v%0d shared", id), 64'(bus.rsp_shared_o), 64'(v.exp[2]));
    chk($sformatf("v%0d writeback", id), 64'(bus.rsp_writeback_o), 64'(v.exp[1]));
    chk($sformatf("v%0d error", id), 64'(bus.rsp_error_o), 64'(v.exp[0]));
    chk($sformatf("v%0d excl_load", id), 64'(bus.rsp_excl_load_o), 64'(v.acc[1]));
    chk($sformatf("v%0d excl_store", id), 64'(bus.rsp_excl_store_o), 64'(v.acc[0]));

    for (int h = 0; h < v.hold; h++) begin
      @(posedge clk);
      @(negedge clk);
      chk($sformatf("v%0d hold%0d req_ready", id, h), 64'(bus.req_ready_o), 64'd0);
      chk($sformatf("v%0d hold%0d rsp_valid", id, h), 64'(bus.rsp_valid_o), 64'd1);
      chk($sformatf("v%0d hold%0d outputs", id, h), 64'(outs()), 64'({v.exp, v.esrc}));
      chk($sformatf("v%0d hold%0d ac_addr", id, h), bus.ac_addr_o, addr);
    end

    bus.rsp_ready_i = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.rsp_ready_i = 1'b0;
    chk($sformatf("v%0d back_to_idle", id), 64'({bus.req_ready_o, bus.rsp_valid_o}), 64'b10);
  endtask

  initial begin
    //            src trs      acc       r0        r1        r2        r3        acd      crd      early  hold lat exp       src
    vt[0]  = mk(0, 4'b0001, 5'b11100, 5'b00000, 5'b00000, 5'b00000, 5'b00000, 16'h0000, 16'h0000, 4'b0000, 0, 3,  5'b00000, 2'd0);
    vt[1]  = mk(0, 4'b0001, 5'b11100, 5'b00000, 5'b00000, 5'b00101, 5'b01001, 16'h0000, 16'h0000, 4'b0000, 0, 3,  5'b11100, 2'd2);
    vt[2]  = mk(0, 4'b0000, 5'b00100, 5'b00000, 5'b00101, 5'b00000, 5'b00000, 16'h0000, 16'h0000, 4'b0000, 0, 3,  5'b10010, 2'd1);
    vt[3]  = mk(2, 4'b1011, 5'b10001, 5'b00010, 5'b00000, 5'b00000, 5'b00000, 16'h0000, 16'h0000, 4'b0000, 0, 3,  5'b00001, 2'd0);
    vt[4]  = mk(1, 4'b0001, 5'b11000, 5'b00000, 5'b00000, 5'b00000, 5'b01000, 16'h0000, 16'h0000, 4'b0000, 0, 3,  5'b00101, 2'd0);
    vt[5]  = mk(3, 4'b0001, 5'b00110, 5'b00100, 5'b00000, 5'b00000, 5'b00000, 16'h0000, 16'h0000, 4'b0000, 0, 3,  5'b00011, 2'd0);
    vt[6]  = mk(0, 4'b0001, 5'b10100, 5'b00000, 5'b01101, 5'b00000, 5'b00000, 16'h0000, 16'h0000, 4'b0000, 0, 3,  5'b10110, 2'd1);
    vt[7]  = mk(0, 4'b0001, 5'b11100, 5'b00000, 5'b00001, 5'b00000, 5'b00001, 16'h0000, 16'h0000, 4'b0000, 5, 3,  5'b10000, 2'd1);
    vt[8]  = mk(0, 4'b0001, 5'b11100, 5'b00000, 5'b00001, 5'b00001, 5'b00001, 16'h0030, 16'h0500, 4'b0000, 0, 8,  5'b10000, 2'd1);
    vt[9]  = mk(0, 4'b0001, 5'b11100, 5'b00000, 5'b00000, 5'b00000, 5'b01000, 16'hA000, 16'h0000, 4'b1000, 0, 13, 5'b00100, 2'd0);
    vt[10] = mk(3, 4'b0001, 5'b11100, 5'b00001, 5'b00001, 5'b00001, 5'b00000, 16'h0000, 16'h0012, 4'b0000, 0, 5,  5'b10000, 2'd0);

    idle_inputs();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    chk("reset req_ready", 64'(bus.req_ready_o), 64'd1);
    chk("reset ac_valid", 64'(bus.ac_valid_o), 64'd0);
    chk("reset cr_ready", 64'(bus.cr_ready_o), 64'd0);
    chk("reset rsp_valid", 64'(bus.rsp_valid_o), 64'd0);
    chk("reset rsp_fields", 64'({outs(), bus.rsp_excl_load_o, bus.rsp_excl_store_o}), 64'd0);

    for (int i = 0; i < 11; i++) run_vec(vt[i], i);

    // Abort a snoop after one CR carrying DataTransfer/Error/PassDirty was merged.
    bus.req_valid_i = 1'b1;
    bus.req_src_i   = 2'd0;
    bus.req_addr_i  = 64'h1234_5678;
    bus.req_info_i  = {4'b0001, 5'b11111};
    bus.ac_ready_i  = 4'b1111;
    @(posedge clk);
    @(negedge clk);
    bus.req_valid_i = 1'b0;
    @(posedge clk);
    @(negedge clk);
    bus.cr_resp_i[1] = 5'b00111;
    bus.cr_valid_i   = 4'b0010;
    chk("abort cr_ready_p1", 64'(bus.cr_ready_o[1]), 64'd1);
    @(posedge clk);
    @(negedge clk);
    bus.cr_valid_i = '0;
    bus.ac_ready_i = '0;
    chk("abort still_busy", 64'({bus.req_ready_o, bus.rsp_valid_o}), 64'b00);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    chk("abort ac_valid", 64'(bus.ac_valid_o), 64'd0);
    chk("abort cr_ready", 64'(bus.cr_ready_o), 64'd0);
    chk("abort req_ready", 64'(bus.req_ready_o), 64'd1);
    chk("abort rsp_valid", 64'(bus.rsp_valid_o), 64'd0);
    run_vec(vt[0], 11);

    $display("== %0d vectors applied, %0d miscompares ==", n_chk, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
